ad9516_cfg_sequencer: RTL and testbench



---
 rtl/ad9516_pkg.sv | 31 +++
 rtl/ad9516_spi_shift.sv | 63 ++++++
 rtl/ad9516_cfg_sequencer.sv | 129 ++++++++++++
 tb/tb_ad9516_cfg_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ad9516_pkg.sv
// Shared types and constants for the AD9516 power-up configuration sequencer.
// Table words are {R/W=0, W1:W0=00, 13-bit register address, 8-bit data}.
package ad9516_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      GAP,
      SETTLE,
      DONE
   } state_t;

   localparam int WORD_W    = 24;
   localparam int INSTR_MSB = 23;
   localparam int INSTR_LSB = 8;
   localparam int DATA_MSB  = 7;
   localparam int DATA_LSB  = 0;

   localparam logic [12:0] REG_SPI_CFG   = 13'h000;
   localparam logic [12:0] REG_IO_UPDATE = 13'h232;
   localparam logic [7:0]  IO_UPDATE_GO  = 8'h01;

   // Single-byte write instruction, used when building the ROM image.
   function automatic logic [WORD_W-1:0] ad_write(input logic [12:0] reg_addr,
                                                  input logic [7:0]  reg_data);
      return {3'b000, reg_addr, reg_data};
   endfunction

endpackage

// File: rtl/ad9516_spi_shift.sv
// 24-bit MSB-first SPI shifter with SCLK divider; data changes on SCLK falls only.
// last_bit_done flags the final cycle of the 24th SCLK high phase.
module ad9516_spi_shift
   import ad9516_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [WORD_W-1:0] word,
   input  logic              active,
   output logic              sclk,
   output logic              sdio,
   output logic              last_bit_done
);

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]  div_cnt;
   logic [4:0]        bit_cnt;
   logic [WORD_W-1:0] shift_reg;
   logic              phase_end;

   assign phase_end     = (div_cnt == DIV_LAST);
   assign last_bit_done = active & sclk & phase_end & (bit_cnt == 5'd0);
   // The shifter MSB is the pin driver; zeros shifted in leave sdio low after the word.
   assign sdio          = shift_reg[WORD_W-1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         sclk      <= 1'b0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
      end else if (load) begin
         shift_reg <= word;
         sclk      <= 1'b0;
         div_cnt   <= '0;
         bit_cnt   <= 5'(WORD_W - 1);
      end else if (active) begin
         if (phase_end) begin
            div_cnt <= '0;
            if (!sclk) begin
               sclk <= 1'b1;
            end else begin
               sclk      <= 1'b0;
               shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
               if (bit_cnt != 5'd0) begin
                  bit_cnt <= bit_cnt - 5'd1;
               end
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end else begin
         sclk    <= 1'b0;
         div_cnt <= '0;
      end
   end

endmodule

// File: rtl/ad9516_cfg_sequencer.sv
// Walks the AD9516 configuration ROM, sending each word over 3-wire SPI with a
// CSB gap between words, then waits a settle delay and raises a sticky done.
module ad9516_cfg_sequencer
   import ad9516_pkg::*;
#(
   parameter int ADDR_W        = 7,
   parameter int N_ENTRIES     = 65,
   parameter int CLK_DIV       = 4,
   parameter int GAP_CYCLES    = 8,
   parameter int SETTLE_CYCLES = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic              spi_csb,
   output logic              spi_sclk,
   output logic              spi_sdio,
   output logic              busy,
   output logic              done
);

   localparam int TMR_MAX = (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0]  GAP_LAST    = TMR_W'(GAP_CYCLES - 1);
   localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(N_ENTRIES - 1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr_n;
   logic [TMR_W-1:0]  tmr, tmr_n;
   logic              csb_n, busy_n, done_n;
   logic              last_bit_done;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rom_addr <= '0;
         tmr      <= '0;
         spi_csb  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         rom_addr <= addr_n;
         tmr      <= tmr_n;
         spi_csb  <= csb_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      addr_n  = rom_addr;
      tmr_n   = tmr;
      csb_n   = spi_csb;
      busy_n  = busy;
      done_n  = done;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = FETCH;
               addr_n  = '0;
               busy_n  = 1'b1;
               done_n  = 1'b0;
            end
         end
         FETCH: state_n = LOAD;
         LOAD: begin
            state_n = SHIFT;
            csb_n   = 1'b0;
         end
         SHIFT: begin
            if (last_bit_done) begin
               state_n = GAP;
               csb_n   = 1'b1;
               tmr_n   = '0;
            end
         end
         GAP: begin
            if (tmr == GAP_LAST) begin
               tmr_n = '0;
               if (rom_addr == LAST_ADDR) begin
                  if (SETTLE_CYCLES == 0) begin
                     state_n = DONE;
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                  end else begin
                     state_n = SETTLE;
                  end
               end else begin
                  addr_n  = rom_addr + 1'b1;
                  state_n = FETCH;
               end
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         SETTLE: begin
            if (tmr == SETTLE_LAST) begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               tmr_n   = '0;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   ad9516_spi_shift #(
      .CLK_DIV(CLK_DIV)
   ) u_shift (
      .clock        (clock),
      .reset        (reset),
      .load         (state == LOAD),
      .word         (rom_data),
      .active       (state == SHIFT),
      .sclk         (spi_sclk),
      .sdio         (spi_sdio),
      .last_bit_done(last_bit_done)
   );

endmodule

// File: tb/tb_ad9516_cfg_sequencer.sv
// Directed bench for the AD9516 configuration sequencer: two configurations,
// SPI words decoded from the pins and checked against a queued scoreboard.
module tb_ad9516_cfg_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  start_v;
   logic [1:0]  csb_v, sclk_v, sdio_v, busy_v, done_v;
   logic [6:0]  addr_a, addr_b;
   logic [23:0] rdata_a, rdata_b;

   int          vec_cnt  = 0;
   int          fail_cnt = 0;
   logic [23:0] exp_q[$];

   always #5 clk = ~clk;

   // Configuration table contents for each device under test.
   function automatic logic [23:0] tbl_word(input int d, input int i);
      if (d == 0) begin
         case (i)
            0:       return 24'h000018;
            1:       return 24'h00F001;
            2:       return 24'h023201;
            default: return 24'hBAD0BA;
         endcase
      end
      return (i == 0) ? 24'h023218 : 24'hBAD0BA;
   endfunction

   always @(posedge clk) begin
      rdata_a <= tbl_word(0, int'(addr_a));
      rdata_b <= tbl_word(1, int'(addr_b));
   end

   ad9516_cfg_sequencer #(
      .ADDR_W(7), .N_ENTRIES(3), .CLK_DIV(2), .GAP_CYCLES(4), .SETTLE_CYCLES(7)
   ) dut_a (
      .clock(clk), .reset(reset), .start(start_v[0]), .rom_addr(addr_a), .rom_data(rdata_a),
      .spi_csb(csb_v[0]), .spi_sclk(sclk_v[0]), .spi_sdio(sdio_v[0]),
      .busy(busy_v[0]), .done(done_v[0])
   );

   ad9516_cfg_sequencer #(
      .ADDR_W(7), .N_ENTRIES(1), .CLK_DIV(1), .GAP_CYCLES(2), .SETTLE_CYCLES(0)
   ) dut_b (
      .clock(clk), .reset(reset), .start(start_v[1]), .rom_addr(addr_b), .rom_data(rdata_b),
      .spi_csb(csb_v[1]), .spi_sclk(sclk_v[1]), .spi_sdio(sdio_v[1]),
      .busy(busy_v[1]), .done(done_v[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp)
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // One full configuration pass, started at a negedge. Cycle 1 is the cycle
   // after the edge that samples start. inj>0 pulses start again at that cycle.
   task automatic run_pass(input int d, input int n, input int c, input int g,
                           input int s, input int inj);
      int          w = 2 + 48 * c + g;
      int          cyc = 0, done_cyc = 0, busy_cnt = 0, words = 0;
      int          low_start = 0, rises = 0, sdio_bad = 0, addr_bad = 0;
      logic [23:0] rx = '0;
      logic [6:0]  cur_addr;
      logic        pcsb, psclk, psdio;
      for (int i = 0; i < n; i++) exp_q.push_back(tbl_word(d, i));
      pcsb  = csb_v[d];
      psclk = sclk_v[d];
      psdio = sdio_v[d];
      start_v[d] = 1'b1;
      @(posedge clk);
      while (done_cyc == 0 && cyc < n * w + s + 40) begin
         @(negedge clk);
         cyc++;
         start_v[d] = (inj != 0 && cyc == inj);
         cur_addr = (d == 0) ? addr_a : addr_b;
         if (cyc == 1) begin
            chk("done_clears", done_v[d], 0);
            chk("busy_rises", busy_v[d], 1);
         end
         if (busy_v[d]) busy_cnt++;
         if (int'(cur_addr) > n - 1) addr_bad++;
         if (!csb_v[d] && pcsb) begin
            chk("csb_fall_cycle", cyc, 3 + words * w);
            chk("rom_addr_seq", cur_addr, words);
            low_start = cyc;
            rises     = 0;
            rx        = '0;
         end
         if (!csb_v[d] && !pcsb) begin
            if (sclk_v[d] && !psclk) begin
               rx = {rx[22:0], sdio_v[d]};
               rises++;
            end
            if (sdio_v[d] != psdio && !(psclk && !sclk_v[d])) sdio_bad++;
         end
         if (csb_v[d] && !pcsb) begin
            chk("sclk_rises", rises, 24);
            chk("csb_low_len", cyc - low_start, 48 * c);
            if (exp_q.size() > 0) chk("spi_word", rx, exp_q.pop_front());
            else chk("sb_extra_word", words + 1, n);
            words++;
         end
         if (done_v[d]) done_cyc = cyc;
         pcsb  = csb_v[d];
         psclk = sclk_v[d];
         psdio = sdio_v[d];
      end
      chk("done_cycle", done_cyc, n * w + s + 1);
      chk("busy_cycles", busy_cnt, n * w + s);
      chk("words_sent", words, n);
      chk("sb_empty", exp_q.size(), 0);
      chk("sdio_stable", sdio_bad, 0);
      chk("addr_range", addr_bad, 0);
      @(negedge clk);
      chk("end_csb", csb_v[d], 1);
      chk("end_sclk", sclk_v[d], 0);
      chk("end_busy", busy_v[d], 0);
      chk("end_done", done_v[d], 1);
      exp_q.delete();
   endtask

   task automatic abort_mid_word();
      int   rises = 0, k = 0;
      logic psclk;
      start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      psclk = sclk_v[0];
      while (rises < 10 && k < 500) begin
         @(negedge clk);
         k++;
         if (sclk_v[0] && !psclk) rises++;
         psclk = sclk_v[0];
      end
      chk("abort_rise10", rises, 10);
      chk("abort_csb_low", csb_v[0], 0);
      reset = 1'b1;
      #1;
      chk("abort_csb", csb_v[0], 1);
      chk("abort_sclk", sclk_v[0], 0);
      chk("abort_busy", busy_v[0], 0);
      chk("abort_done", done_v[0], 0);
      chk("abort_addr", addr_a, 0);
      // A start held across the release of reset must be lost.
      start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset      = 1'b0;
      start_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk("start_lost_busy", busy_v[0], 0);
      chk("start_lost_csb", csb_v[0], 1);
   endtask

   initial begin
      reset   = 1'b1;
      start_v = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_csb", csb_v, 2'b11);
      chk("rst_sclk", sclk_v, 2'b00);
      chk("rst_sdio", sdio_v, 2'b00);
      chk("rst_busy", busy_v, 2'b00);
      chk("rst_done", done_v, 2'b00);
      chk("rst_addr", {addr_b, addr_a}, 14'h0);
      reset = 1'b0;
      @(negedge clk);

      run_pass(1, 1, 1, 2, 0, 0);
      run_pass(0, 3, 2, 4, 7, 0);
      run_pass(0, 3, 2, 4, 7, 3 + 102 + 40);
      abort_mid_word();
      run_pass(0, 3, 2, 4, 7, 0);
      run_pass(1, 1, 1, 2, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
      $finish;
   end

endmodule
